// File: rtl/console_rx.sv
// 8N1 serial console receiver with a byte FIFO and a two-register bus slave.
// DATA pops the head byte; STATUS reports flags and the FIFO fill level.
module console_rx #(
   parameter int CLK_DIV    = 104,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rx,
   input  logic        sel,
   input  logic        addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        irq
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [15:0]   HALF_CNT = 16'(CLK_DIV / 2 - 1);
   localparam logic [15:0]   BIT_CNT  = 16'(CLK_DIV - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t          state_q, state_d;
   logic            rx_meta_q, rxs_q;
   logic [15:0]     cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovr_q, ovr_d, frm_q, frm_d;
   logic            sel_prev_q, ready_q, ready_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic            push_req, frm_set, pop, push_ok, ovr_set, wr_status;
   logic [31:0]     status;
   logic            unused_wdata;

   assign unused_wdata = ^{wdata[31:3], wdata[0]};

   // State register, synchronizer and control flops
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         idx_q      <= 3'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovr_q      <= 1'b0;
         frm_q      <= 1'b0;
         sel_prev_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         rx_meta_q  <= rx;
         rxs_q      <= rx_meta_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovr_q      <= ovr_d;
         frm_q      <= frm_d;
         sel_prev_q <= sel;
         ready_q    <= ready_d;
      end
   end

   // Shift register and FIFO storage carry data only
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      if (push_ok) mem_q[wr_ptr_q] <= shift_q;
   end

   // Receiver next-state: counter samples mid-bit once the start edge is seen
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      case (state_q)
         S_IDLE: begin
            if (!rxs_q) begin
               state_d = S_START;
               cnt_d   = HALF_CNT;
            end
         end
         S_START: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (rxs_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DATA;
               cnt_d   = BIT_CNT;
               idx_d   = 3'd0;
            end
         end
         S_DATA: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shift_d[idx_q] = rxs_q;
               cnt_d          = BIT_CNT;
               if (idx_q == 3'd7) state_d = S_STOP;
               else               idx_d   = idx_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q != 16'd0)  cnt_d   = cnt_q - 1'b1;
            else if (rxs_q)      state_d = S_IDLE;
            else                 state_d = S_BREAK;
         end
         S_BREAK: begin
            if (rxs_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Receiver outputs
   always_comb begin
      push_req = 1'b0;
      frm_set  = 1'b0;
      if (state_q == S_STOP && cnt_q == 16'd0) begin
         push_req = rxs_q;
         frm_set  = !rxs_q;
      end
   end

   // FIFO bookkeeping and flags; a pop in the same cycle makes room for a push
   always_comb begin
      ready_d   = sel && !sel_prev_q;
      pop       = ready_q && !we && !addr && (count_q != '0);
      wr_status = ready_q && we && addr;
      push_ok   = push_req && ((count_q != FULL_CNT) || pop);
      ovr_set   = push_req && !push_ok;
      wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d   = count_q;
      if (push_ok && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push_ok) count_d = count_q - 1'b1;
      ovr_d = ovr_q;
      frm_d = frm_q;
      if (wr_status && wdata[1]) ovr_d = 1'b0;
      if (wr_status && wdata[2]) frm_d = 1'b0;
      if (ovr_set)               ovr_d = 1'b1;
      if (frm_set)               frm_d = 1'b1;
   end

   // Read mux, driven only while ready is high
   always_comb begin
      status = {15'h0, 9'(count_q), 5'h0, frm_q, ovr_q, (count_q != '0)};
      rdata  = 32'h0;
      if (ready_q && !we) begin
         if (addr)                rdata = status;
         else if (count_q != '0)  rdata = {24'h0, mem_q[rd_ptr_q]};
         else                     rdata = 32'hFFFF_FFFF;
      end
   end

   assign ready = ready_q;
   assign irq   = (count_q != '0);

endmodule

// File: tb/tb_console_rx.sv
// Randomized bench for console_rx against a queue-based model of the
// receive FIFO and its status flags.
module tb_console_rx;
   localparam int CLK_DIV = 104;
   localparam int DEPTH   = 16;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        rx = 1'b1;
   logic        sel = 1'b0;
   logic        addr = 1'b0;
   logic        we = 1'b0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        ready;
   logic        irq;

   console_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn), .rx(rx), .sel(sel), .addr(addr),
      .we(we), .wdata(wdata), .rdata(rdata), .ready(ready), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mq[$];
   bit         m_ovr = 1'b0;
   bit         m_frm = 1'b0;

   logic [31:0] rd;
   logic        ir_at, ir_after;
   logic [7:0]  b, b17, head;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      return {15'h0, 9'(mq.size()), 5'h0, m_frm, m_ovr, mq.size() != 0};
   endfunction

   // One 8N1 frame; a bad stop bit is stretched into a line break
   task automatic send_byte(input logic [7:0] v, input bit stop_ok, input int hold_low);
      @(negedge clk);
      rx = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = v[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      rx = stop_ok;
      repeat (CLK_DIV) @(negedge clk);
      if (!stop_ok) repeat (hold_low) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic model_frame(input logic [7:0] v, input bit stop_ok);
      if (!stop_ok)             m_frm = 1'b1;
      else if (mq.size() < DEPTH) mq.push_back(v);
      else                      m_ovr = 1'b1;
   endtask

   task automatic bus(input bit a, input bit w, input logic [31:0] wd,
                      output logic [31:0] r, output logic irq_r, output logic irq_n);
      int k;
      sel = 1'b1; addr = a; we = w; wdata = wd;
      r = 32'hDEAD_DEAD; irq_r = 1'b0; irq_n = 1'b0;
      for (k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ready) break;
      end
      if (!ready) begin
         chk("ready_timeout", {31'h0, ready}, 32'h1);
         sel = 1'b0;
         @(negedge clk);
      end else begin
         chk("ready_latency", k, 0);
         r = rdata; irq_r = irq;
         @(negedge clk);
         chk("ready_single", {31'h0, ready}, 32'h0);
         irq_n = irq;
         sel = 1'b0; we = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic read_data();
      logic [31:0] e;
      e = (mq.size() != 0) ? {24'h0, mq.pop_front()} : 32'hFFFF_FFFF;
      bus(1'b0, 1'b0, 32'h0, rd, ir_at, ir_after);
      chk("rd_data", rd, e);
   endtask

   task automatic read_status();
      logic [31:0] e;
      e = exp_status();
      bus(1'b1, 1'b0, 32'h0, rd, ir_at, ir_after);
      chk("rd_status", rd, e);
   endtask

   task automatic write_status(input logic [31:0] wd);
      bus(1'b1, 1'b1, wd, rd, ir_at, ir_after);
      if (wd[1]) m_ovr = 1'b0;
      if (wd[2]) m_frm = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, ready}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      resetn = 1'b1;
      mq.delete(); m_ovr = 1'b0; m_frm = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Empty reads after reset
      read_data();
      chk("empty_data", rd, 32'hFFFF_FFFF);
      read_status();
      chk("empty_status", rd, 32'h0);

      // Single byte 0x41
      send_byte(8'h41, 1'b1, 0); model_frame(8'h41, 1'b1);
      repeat (4) @(negedge clk);
      read_status();
      chk("status_41", rd, 32'h0000_0101);
      read_data();
      chk("data_41", rd, 32'h0000_0041);
      chk("irq_in_ready", {31'h0, ir_at}, 32'h1);
      chk("irq_after_pop", {31'h0, ir_after}, 32'h0);

      // Overrun: 17 bytes into a 16-entry FIFO
      for (int i = 0; i <= 16; i++) begin
         send_byte(8'(i), 1'b1, 0); model_frame(8'(i), 1'b1);
      end
      repeat (4) @(negedge clk);
      read_status();
      chk("status_ovr", rd, 32'h0000_1003);
      for (int i = 0; i < 17; i++) read_data();
      write_status(32'h2);
      read_status();
      chk("ovr_cleared", rd & 32'h2, 32'h0);

      // Framing error followed by a clean byte
      send_byte(8'h55, 1'b0, 500); model_frame(8'h55, 1'b0);
      repeat (10) @(negedge clk);
      read_status();
      chk("frm_set", rd, 32'h0000_0004);
      send_byte(8'h33, 1'b1, 0); model_frame(8'h33, 1'b1);
      repeat (4) @(negedge clk);
      read_data();
      write_status(32'h4);

      // Glitch shorter than half a bit
      @(negedge clk); rx = 1'b0;
      repeat (30) @(negedge clk); rx = 1'b1;
      repeat (100) @(negedge clk);
      read_status();
      chk("glitch_status", rd, 32'h0);
      chk("glitch_irq", {31'h0, irq}, 32'h0);

      // Fill the FIFO, then pop exactly on the cycle the 17th byte lands
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom_range(0, 255));
         send_byte(b, 1'b1, 0); model_frame(b, 1'b1);
      end
      b17  = 8'($urandom_range(0, 255));
      head = mq[0];
      fork
         send_byte(b17, 1'b1, 0);
         begin
            repeat (990) @(negedge clk);
            bus(1'b0, 1'b0, 32'h0, rd, ir_at, ir_after);
         end
      join
      chk("conc_pop", rd, {24'h0, head});
      void'(mq.pop_front());
      model_frame(b17, 1'b1);
      repeat (4) @(negedge clk);
      read_status();
      chk("conc_status", rd, 32'h0000_1001);
      for (int i = 0; i < DEPTH; i++) read_data();

      // Framing error set and write-1-clear in the same cycle
      fork
         send_byte(8'hA5, 1'b0, 200);
         begin
            repeat (990) @(negedge clk);
            bus(1'b1, 1'b1, 32'h4, rd, ir_at, ir_after);
         end
      join
      m_frm = 1'b1;
      repeat (10) @(negedge clk);
      read_status();
      write_status(32'h6);

      // Randomized traffic
      for (int it = 0; it < 12; it++) begin
         bit ok;
         int nops;
         b  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 5) != 0);
         send_byte(b, ok, $urandom_range(50, 300)); model_frame(b, ok);
         repeat (8) @(negedge clk);
         nops = $urandom_range(0, 3);
         for (int j = 0; j < nops; j++) begin
            case ($urandom_range(0, 3))
               0: read_data();
               1: read_status();
               2: write_status($urandom);
               default: bus(1'b0, 1'b1, $urandom, rd, ir_at, ir_after);
            endcase
         end
      end
      read_status();
      while (mq.size() != 0) read_data();
      read_data();

      // Reset in the middle of a frame abandons the byte
      @(negedge clk); rx = 1'b0;
      repeat (CLK_DIV) @(negedge clk); rx = 1'b1;
      repeat (300) @(negedge clk);
      do_reset();
      repeat (1000) @(negedge clk);
      read_status();
      chk("midreset_status", rd, 32'h0);
      read_data();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
